// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: widths, reset PC default, fetch FSM states.
// Queue entry bundle carries an instruction word with its fetch address.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Head word is read straight from storage; the caller prevents overflow.
import riscv_pkg::*;

module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_pop;

    assign do_pop = pop & (cnt != '0);
    assign rdata  = mem[rd_ptr];
    assign count  = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// RV32I fetch front end: PC, credit-limited imem requests, instruction queue.
// Optional misaligned-redirect halt is built with FETCH_ALIGN_CHECK_EN.
import riscv_pkg::*;

module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state;
    fetch_state_e  state_n;
    logic [31:0]   pc;
    logic [31:0]   redir_pc;
    logic [31:0]   tag_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] dcount;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credit;
    logic          accept;
    logic          dropping;
    logic          push;
    fetch_entry_t  push_e;
    fetch_entry_t  head;

    assign credit   = {1'b0, outstanding} + {1'b0, dcount};
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
    assign dropping = drop_cnt != '0;

    assign imem_req_valid = (state == RUN) & !redirect_valid
                          & (credit < (CW+1)'(FIFO_DEPTH));
    assign imem_addr      = pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign push          = imem_rsp_valid & !dropping & !redirect_valid;
    assign push_e.instr  = imem_rsp_data;
    assign push_e.pc     = tag_pc;

    assign instr_valid = dcount != '0;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // Tag queue tracks every accepted request, dropped or not.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (1'b0),
        .push    (accept),
        .wdata   (pc),
        .pop     (imem_rsp_valid),
        .rdata   (tag_pc),
        .count   (outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_data_q (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .push    (push),
        .wdata   (push_e),
        .pop     (instr_valid & instr_ready),
        .rdata   (head),
        .count   (dcount)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (fetch_en)  state_n = RUN;
            RUN:     if (!fetch_en) state_n = IDLE;
            default: state_n = state;
        endcase
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) state_n = HALT;
            else if (state == HALT)        state_n = RUN;
            else                           state_n = state;
`else
            state_n = state;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state <= state_n;
            if (redirect_valid) begin
                pc       <= redir_pc;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (imem_rsp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else if (redirect_valid) begin
            misaligned_q <= redirect_pc[1:0] != 2'b00;
        end
    end

    assign fetch_misaligned = misaligned_q;
`else
    assign fetch_misaligned = 1'b0;
`endif

endmodule
